// File: rtl/keypad_scanner_n.sv
// keypad_scanner_n: debounced ROWSxCOLS matrix keypad scanner with
// auto-repeat and a key-code FIFO (valid/ready pop, sticky overflow).
module keypad_scanner_n #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 50_000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int REPEAT_DELAY   = 1000,
    parameter int REPEAT_RATE    = 200,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                         clk_in,
    input  logic                         rst,
    input  logic [COLS-1:0]              col_in,
    output logic [ROWS-1:0]              row_out,
    output logic [$clog2(ROWS*COLS)-1:0] key_code,
    output logic                         key_valid,
    input  logic                         key_ready,
    output logic                         key_held,
    output logic                         ovf,
    input  logic                         ovf_clr
);
    localparam int CW   = $clog2(ROWS * COLS);
    localparam int TW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW   = $clog2(DEBOUNCE_TICKS + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int PW   = $clog2(RMAX + 1);
    localparam int RW   = $clog2(ROWS);
    localparam int KW   = $clog2(COLS);
    localparam int AW   = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, DEBOUNCE, SCAN, HELD, RELEASE} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] div_q, div_d;
    logic [DW-1:0] db_q, db_d, db_inc;
    logic [PW-1:0] rep_q, rep_d, rep_inc;
    logic          rate_q, rate_d;
    logic [RW-1:0] r_q, r_d;
    logic [KW-1:0] c_q, c_d;
    logic          tick, col_any, key_up, push;
    logic [KW-1:0] col_idx, code_col;
    logic [CW-1:0] push_code;

    logic [CW-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]   wp_q, rp_q;
    logic          ovf_q, ovf_d;
    logic          empty, full, pop, wr;

    assign tick    = (div_q == TW'(SCAN_DIV - 1));
    assign div_d   = tick ? '0 : div_q + 1'b1;
    assign col_any = ~&col_in;
    assign key_up  = col_in[c_q];
    assign db_inc  = db_q + 1'b1;
    assign rep_inc = rep_q + 1'b1;

    // Lowest low column wins when several keys share the driven row.
    always_comb begin
        col_idx = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (!col_in[c]) col_idx = KW'(c);
        end
    end

    assign code_col  = (state_q == SCAN) ? col_idx : c_q;
    assign push_code = CW'(int'(r_q) * COLS + int'(code_col));

    always_comb begin
        state_d = state_q;
        db_d    = db_q;
        rep_d   = rep_q;
        rate_d  = rate_q;
        r_d     = r_q;
        c_d     = c_q;
        push    = 1'b0;
        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (col_any) begin
                        state_d = DEBOUNCE;
                        db_d    = '0;
                    end
                end
                DEBOUNCE: begin
                    if (!col_any) begin
                        state_d = IDLE;
                    end else if (db_q == DW'(DEBOUNCE_TICKS - 1)) begin
                        state_d = SCAN;
                        r_d     = '0;
                    end else begin
                        db_d = db_inc;
                    end
                end
                SCAN: begin
                    if (col_any) begin
                        push    = 1'b1;
                        c_d     = col_idx;
                        state_d = HELD;
                        rep_d   = '0;
                        rate_d  = 1'b0;
                    end else if (r_q == RW'(ROWS - 1)) begin
                        state_d = IDLE;
                    end else begin
                        r_d = r_q + 1'b1;
                    end
                end
                HELD: begin
                    if (key_up) begin
                        if (DEBOUNCE_TICKS == 1) begin
                            state_d = IDLE;
                        end else begin
                            state_d = RELEASE;
                            db_d    = DW'(1);
                        end
                    end else begin
                        rep_d = rep_inc;
                        if (REPEAT_DELAY != 0 && !rate_q &&
                            rep_inc == PW'(REPEAT_DELAY)) begin
                            push   = 1'b1;
                            rep_d  = '0;
                            rate_d = 1'b1;
                        end else if (rate_q && rep_inc == PW'(REPEAT_RATE)) begin
                            push  = 1'b1;
                            rep_d = '0;
                        end
                    end
                end
                RELEASE: begin
                    if (!key_up) begin
                        state_d = HELD;
                    end else if (db_inc == DW'(DEBOUNCE_TICKS)) begin
                        state_d = IDLE;
                    end else begin
                        db_d = db_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        row_out = '0;
        if (state_q == SCAN || state_q == HELD || state_q == RELEASE)
            row_out = ~(ROWS'(1) << r_q);
    end

    assign key_held = (state_q == HELD) || (state_q == RELEASE);

    // Pointers carry an extra wrap bit so full and empty are distinct.
    assign empty = (wp_q == rp_q);
    assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign pop   = !empty && key_ready;
    assign wr    = push && (!full || pop);
    assign ovf_d = (push && full && !pop) ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

    assign key_valid = !empty;
    assign key_code  = empty ? '0 : mem_q[rp_q[AW-1:0]];
    assign ovf       = ovf_q;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            db_q    <= '0;
            rep_q   <= '0;
            rate_q  <= 1'b0;
            r_q     <= '0;
            c_q     <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            db_q    <= db_d;
            rep_q   <= rep_d;
            rate_q  <= rate_d;
            r_q     <= r_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
            if (wr)  wp_q <= wp_q + 1'b1;
            if (pop) rp_q <= rp_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr) mem_q[wp_q[AW-1:0]] <= push_code;
    end

endmodule

// File: tb/tb_keypad_scanner_n.sv
// tb_keypad_scanner_n: randomized key presses on a modelled key matrix,
// expected key codes and push ticks checked through a scoreboard.
module tb_keypad_scanner_n;
    localparam int ROWS = 4, COLS = 4, SD = 4, DB = 2, RD = 3, RR = 2, FD = 2;

    logic            clk_in = 1'b0;
    logic            rst = 1'b0;
    logic [COLS-1:0] col_in;
    logic [ROWS-1:0] row_out;
    logic [3:0]      key_code;
    logic            key_valid, key_ready, key_held, ovf, ovf_clr;

    logic [2:0]      col2;
    logic [1:0]      row2;
    logic [2:0]      code2;
    logic            valid2, ready2, held2, ovf2, ovf_clr2;

    always #5 clk_in = ~clk_in;

    keypad_scanner_n #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE_TICKS(DB),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .FIFO_DEPTH(FD)
    ) dut (
        .clk_in(clk_in), .rst(rst), .col_in(col_in), .row_out(row_out),
        .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
        .key_held(key_held), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    keypad_scanner_n #(
        .ROWS(2), .COLS(3), .SCAN_DIV(SD), .DEBOUNCE_TICKS(DB),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .FIFO_DEPTH(FD)
    ) dut2 (
        .clk_in(clk_in), .rst(rst), .col_in(col2), .row_out(row2),
        .key_code(code2), .key_valid(valid2), .key_ready(ready2),
        .key_held(held2), .ovf(ovf2), .ovf_clr(ovf_clr2)
    );

    // Key matrix: a pressed key pulls its column low while its row is driven low.
    logic kp_en;
    int   kp_r, kp_c;
    logic k2a, k2b;

    always_comb begin
        col_in = '1;
        if (kp_en && !row_out[kp_r]) col_in[kp_c] = 1'b0;
    end

    always_comb begin
        col2 = '1;
        if (k2a && !row2[1]) col2[2] = 1'b0;
        if (k2b && !row2[1]) col2[0] = 1'b0;
    end

    // Tick numbering: tick n is the n-th cycle since reset whose count is SD-1.
    int cyc, tick_num;
    always @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cyc      <= 0;
            tick_num <= 0;
        end else begin
            cyc <= (cyc == SD - 1) ? 0 : cyc + 1;
            if (cyc == SD - 1) tick_num <= tick_num + 1;
        end
    end

    typedef struct packed {
        int code;
        int tick;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic sb_push(int code, int tick);
        exp_t e;
        e.code = code;
        e.tick = tick;
        sb.push_back(e);
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        if (rst && key_valid && key_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got code %0d at tick %0d, required none",
                         key_code, tick_num);
            end else begin
                e = sb.pop_front();
                if (key_code != e.code || (e.tick >= 0 && tick_num != e.tick)) begin
                    errors++;
                    $display("FAIL pop: got code %0d tick %0d, required code %0d tick %0d",
                             key_code, tick_num, e.code, e.tick);
                end
            end
        end
    end

    task automatic sync_tick();
        int t0;
        t0 = tick_num;
        do @(negedge clk_in); while (tick_num == t0);
    endtask

    // Key low on ticks t0..t0+h-1 except relative tick g (g=0: no glitch).
    task automatic expect_press(int r, int c, int h, int g, int t0);
        int cap, cnt;
        cap = t0 + DB + 1 + r;
        if (cap > t0 + h - 1) return;
        sb_push(r * COLS + c, cap);
        cnt = 0;
        for (int t = cap + 1; t <= t0 + h - 1; t++) begin
            if (g != 0 && (t == t0 + g || t == t0 + g + 1)) continue;
            cnt++;
            if (RD != 0 && (cnt == RD || (cnt > RD && (cnt - RD) % RR == 0)))
                sb_push(r * COLS + c, t);
        end
    endtask

    task automatic press(int r, int c, int h, int g, bit model);
        int t0;
        sync_tick();
        t0   = tick_num + 1;
        kp_r = r;
        kp_c = c;
        if (model) expect_press(r, c, h, g, t0);
        for (int i = 0; i < h; i++) begin
            kp_en = !(g != 0 && i == g);
            sync_tick();
        end
        kp_en = 1'b0;
        if (DB + 1 + r <= h - 1) begin
            sync_tick();
            chk("held_in_release", key_held, 1);
            sync_tick();
            chk("held_fall", key_held, 0);
        end
        repeat (DB + ROWS + 2) sync_tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, c, h, g;
        kp_en     = 1'b0;
        kp_r      = 0;
        kp_c      = 0;
        k2a       = 1'b0;
        k2b       = 1'b0;
        key_ready = 1'b1;
        ovf_clr   = 1'b0;
        ready2    = 1'b0;
        ovf_clr2  = 1'b0;

        #1;
        chk("rst_row_out", int'(row_out), 0);
        chk("rst_valid", key_valid, 0);
        chk("rst_code", int'(key_code), 0);
        chk("rst_held", key_held, 0);
        chk("rst_ovf", ovf, 0);
        #21 rst = 1'b1;

        press(2, 1, 8, 0, 1'b1);
        press(0, 0, 1, 0, 1'b1);
        chk("glitch_held", key_held, 0);
        press(0, 3, 16, 0, 1'b1);
        press(0, 3, 16, 8, 1'b1);

        for (int n = 0; n < 25; n++) begin
            r = $urandom_range(ROWS - 1, 0);
            c = $urandom_range(COLS - 1, 0);
            h = $urandom_range(14, 1);
            g = 0;
            if (h - 2 >= DB + 2 + r && $urandom_range(2, 0) == 0)
                g = $urandom_range(h - 2, DB + 2 + r);
            press(r, c, h, g, 1'b1);
        end
        chk("rand_ovf", ovf, 0);
        chk("rand_sb_drained", sb.size(), 0);

        key_ready = 1'b0;
        press(0, 0, DB + 2, 0, 1'b0);
        press(1, 1, DB + 3, 0, 1'b0);
        chk("ovf_full_no_drop", ovf, 0);
        press(3, 3, DB + 5, 0, 1'b0);
        chk("ovf_set", ovf, 1);
        chk("ovf_head", int'(key_code), 0);
        chk("ovf_valid", key_valid, 1);
        sb_push(0, -1);
        sb_push(5, -1);
        @(posedge clk_in);
        #1 key_ready = 1'b1;
        repeat (4) @(negedge clk_in);
        chk("ovf_drained", key_valid, 0);
        chk("ovf_sticky", ovf, 1);
        @(posedge clk_in);
        #1 ovf_clr = 1'b1;
        @(posedge clk_in);
        #1 ovf_clr = 1'b0;
        chk("ovf_clr", ovf, 0);
        chk("ovf_sb_drained", sb.size(), 0);

        key_ready = 1'b0;
        sync_tick();
        kp_r  = 3;
        kp_c  = 0;
        kp_en = 1'b1;
        repeat (10) sync_tick();
        chk("pre_rst_held", key_held, 1);
        chk("pre_rst_valid", key_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_row_out", int'(row_out), 0);
        chk("mid_rst_valid", key_valid, 0);
        chk("mid_rst_held", key_held, 0);
        chk("mid_rst_ovf", ovf, 0);
        sb.delete();
        key_ready = 1'b1;
        #20 rst = 1'b1;
        sb_push(12, DB + 5);
        while (tick_num < DB + 5) sync_tick();
        kp_en = 1'b0;
        repeat (DB + ROWS + 4) sync_tick();
        chk("post_rst_held", key_held, 0);
        chk("post_rst_sb_drained", sb.size(), 0);

        sync_tick();
        k2a = 1'b1;
        repeat (DB + 3) sync_tick();
        chk("ns_code", int'(code2), 5);
        chk("ns_valid", valid2, 1);
        k2a = 1'b0;
        @(posedge clk_in);
        #1 ready2 = 1'b1;
        @(posedge clk_in);
        #1 ready2 = 1'b0;
        chk("ns_popped", valid2, 0);
        repeat (DB + 6) sync_tick();
        k2a = 1'b1;
        k2b = 1'b1;
        repeat (DB + 3) sync_tick();
        chk("ns_lowest_col", int'(code2), 3);
        chk("ns_valid2", valid2, 1);
        k2a = 1'b0;
        k2b = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
